// File: rtl/serial_word_deserializer.sv
// rtl/serial_word_deserializer.sv - rebuilds WIDTH-bit words from a serial stream, MSB- or LSB-first,
// and holds each word in a one-entry valid/ready buffer with a sticky overrun flag.
module serial_word_deserializer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Sin,
  input  logic             Sin_valid,
  input  logic             Msb_first,
  input  logic             Clear,
  output logic [WIDTH-1:0] Word,
  output logic             Word_valid,
  input  logic             Word_ready,
  output logic [CNT_W-1:0] Bit_count,
  output logic             Overrun
);

  typedef enum logic {EMPTY, FULL} buf_state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  buf_state_t       state, next_state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shifted;
  logic             dir_q;
  logic             dir_eff;
  logic             take;
  logic             complete;
  logic             load_word;
  logic             drop_word;

  // Direction is taken live on bit 0 and frozen for the rest of the word.
  assign dir_eff  = (Bit_count == '0) ? Msb_first : dir_q;
  assign shifted  = dir_eff ? {acc[WIDTH-2:0], Sin} : {Sin, acc[WIDTH-1:1]};
  assign take     = Sin_valid & ~Clear;
  assign complete = take & (Bit_count == LAST_BIT);

  assign Word_valid = (state == FULL);

  always_comb begin
    next_state = state;
    load_word  = 1'b0;
    drop_word  = 1'b0;
    case (state)
      EMPTY: begin
        if (complete) begin
          next_state = FULL;
          load_word  = 1'b1;
        end
      end
      FULL: begin
        if (complete) begin
          if (Word_ready) begin
            load_word = 1'b1;
          end else begin
            drop_word = 1'b1;
          end
        end else if (Word_ready) begin
          next_state = EMPTY;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= EMPTY;
      acc       <= '0;
      Bit_count <= '0;
      Word      <= '0;
      Overrun   <= 1'b0;
      dir_q     <= 1'b1;
    end else begin
      state <= next_state;
      if (Clear) begin
        acc       <= '0;
        Bit_count <= '0;
      end else if (Sin_valid) begin
        if (Bit_count == '0) begin
          dir_q <= Msb_first;
        end
        if (complete) begin
          acc       <= '0;
          Bit_count <= '0;
        end else begin
          acc       <= shifted;
          Bit_count <= Bit_count + 1'b1;
        end
      end
      if (load_word) begin
        Word <= shifted;
      end
      if (drop_word) begin
        Overrun <= 1'b1;
      end
    end
  end

endmodule
